// File: rtl/spio_status_led_pager.sv
// spio_status_led_pager: pages NUM_DEVICES status sources onto NUM_LEDS LED
// channels. It scans pages automatically and lets the host hold a chosen page.
// Optional feature macro: SPIO_STATUS_LED_PAGER_STICKY_ACTIVITY_EN. When it is
// defined, activity seen on an off-page device is remembered and flashed once
// when that device's page is next shown.
module spio_status_led_pager #(
  parameter int unsigned NUM_DEVICES  = 16,
  parameter int unsigned NUM_LEDS     = 4,
  parameter int unsigned PAGE_REPEATS = 2,
  parameter int unsigned HOLD_REPEATS = 8,
  parameter int unsigned PAGE_BITS    = 2
) (
  input  logic                   CLK_IN,
  input  logic                   RESET_IN,
  input  logic [NUM_DEVICES-1:0] ERROR_IN,
  input  logic [NUM_DEVICES-1:0] CONNECTED_IN,
  input  logic [NUM_DEVICES-1:0] ACTIVITY_IN,
  input  logic                   ANIMATION_REPEAT_IN,
  input  logic                   OVERRIDE_VLD_IN,
  input  logic [PAGE_BITS-1:0]   OVERRIDE_PAGE_IN,
  output logic                   OVERRIDE_RDY_OUT,
  output logic [NUM_LEDS-1:0]    ERROR_OUT,
  output logic [NUM_LEDS-1:0]    CONNECTED_OUT,
  output logic [NUM_LEDS-1:0]    ACTIVITY_OUT,
  output logic [PAGE_BITS-1:0]   PAGE_OUT,
  output logic                   PAGE_STROBE_OUT,
  output logic                   HOLD_OUT
);

  localparam int unsigned NUM_PAGES   = (NUM_DEVICES + NUM_LEDS - 1) / NUM_LEDS;
  localparam int unsigned MAX_REPEATS = (PAGE_REPEATS > HOLD_REPEATS) ? PAGE_REPEATS : HOLD_REPEATS;
  localparam int unsigned CNT_BITS    = $clog2(MAX_REPEATS + 1);

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [PAGE_BITS-1:0]    page_q, page_d;
  logic [CNT_BITS-1:0]     cnt_q, cnt_d;
  logic                    strobe_d;
  logic                    xfer;
  int unsigned             shamt;
  logic [NUM_DEVICES-1:0]  act_src;
  logic [NUM_LEDS-1:0]     err_c, con_c, act_c;

  // Next-state logic: host transfer wins over a same-cycle repeat pulse
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    xfer     = OVERRIDE_VLD_IN & OVERRIDE_RDY_OUT;
    if (xfer) begin
      // Out-of-range pages complete the handshake but are otherwise ignored
      if (32'(OVERRIDE_PAGE_IN) < NUM_PAGES) begin
        page_d   = OVERRIDE_PAGE_IN;
        cnt_d    = '0;
        state_d  = ST_HOLD;
        strobe_d = 1'b1;
      end
    end else if (ANIMATION_REPEAT_IN) begin
      if (state_q == ST_HOLD) begin
        if (32'(cnt_q) == HOLD_REPEATS - 1) begin
          cnt_d   = '0;
          state_d = ST_SCAN;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end else begin
        if (32'(cnt_q) == PAGE_REPEATS - 1) begin
          cnt_d    = '0;
          strobe_d = 1'b1;
          page_d   = (32'(page_q) == NUM_PAGES - 1) ? '0 : page_q + PAGE_BITS'(1);
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
    end
  end

`ifdef SPIO_STATUS_LED_PAGER_STICKY_ACTIVITY_EN
  logic [NUM_DEVICES-1:0] pending_q, pending_d;
  logic [NUM_DEVICES-1:0] on_page;

  // Pending flags: latch off-page activity, drop it once its page is shown
  always_comb begin
    on_page   = NUM_DEVICES'({{NUM_DEVICES{1'b0}}, {NUM_LEDS{1'b1}}} << shamt);
    pending_d = (pending_q & ~(PAGE_STROBE_OUT ? on_page : '0)) | (ACTIVITY_IN & ~on_page);
    act_src   = ACTIVITY_IN | (PAGE_STROBE_OUT ? pending_q : '0);
  end

  // Pending flag register
  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end
`else
  // Off-page activity is simply dropped
  always_comb begin
    act_src = ACTIVITY_IN;
  end
`endif

  // Select the displayed page's devices; missing devices read as zero
  always_comb begin
    shamt = 32'(page_q) * NUM_LEDS;
    err_c = NUM_LEDS'({{NUM_LEDS{1'b0}}, ERROR_IN} >> shamt);
    con_c = NUM_LEDS'({{NUM_LEDS{1'b0}}, CONNECTED_IN} >> shamt);
    act_c = NUM_LEDS'({{NUM_LEDS{1'b0}}, act_src} >> shamt);
  end

  // State, page, counter and registered outputs
  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      state_q          <= ST_SCAN;
      page_q           <= '0;
      cnt_q            <= '0;
      OVERRIDE_RDY_OUT <= 1'b0;
      PAGE_STROBE_OUT  <= 1'b0;
      HOLD_OUT         <= 1'b0;
      ERROR_OUT        <= '0;
      CONNECTED_OUT    <= '0;
      ACTIVITY_OUT     <= '0;
    end else begin
      state_q          <= state_d;
      page_q           <= page_d;
      cnt_q            <= cnt_d;
      OVERRIDE_RDY_OUT <= (state_d == ST_SCAN);
      PAGE_STROBE_OUT  <= strobe_d;
      HOLD_OUT         <= (state_d == ST_HOLD);
      ERROR_OUT        <= err_c;
      CONNECTED_OUT    <= con_c;
      ACTIVITY_OUT     <= act_c;
    end
  end

  assign PAGE_OUT = page_q;

endmodule

// File: tb/tb_spio_status_led_pager.sv
// Bench for spio_status_led_pager: behavioural model of the default-parameter
// instance checked every cycle, plus directed literal checks on it and on a
// small 6-device instance.
module tb_spio_status_led_pager;

  localparam int ND = 16;
  localparam int NL = 4;
  localparam int NP = 4;
  localparam int PR = 2;
  localparam int HR = 8;
`ifdef SPIO_STATUS_LED_PAGER_STICKY_ACTIVITY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance signals
  logic [15:0] err_in = '0, con_in = '0, act_in = '0;
  logic        rep = 1'b0, vld = 1'b0;
  logic [1:0]  ovr_page = '0;
  logic        rdy, strobe, hold;
  logic [3:0]  err_out, con_out, act_out;
  logic [1:0]  page_out;

  // Small instance signals
  logic [5:0]  err6 = '0, con6 = '0, act6 = '0;
  logic        rep6 = 1'b0, vld6 = 1'b0;
  logic [1:0]  pg6 = '0;
  logic        rdy6, strobe6, hold6;
  logic [3:0]  err6_out, con6_out, act6_out;
  logic [1:0]  page6_out;

  spio_status_led_pager dut (
    .CLK_IN(clk), .RESET_IN(rst_n),
    .ERROR_IN(err_in), .CONNECTED_IN(con_in), .ACTIVITY_IN(act_in),
    .ANIMATION_REPEAT_IN(rep),
    .OVERRIDE_VLD_IN(vld), .OVERRIDE_PAGE_IN(ovr_page), .OVERRIDE_RDY_OUT(rdy),
    .ERROR_OUT(err_out), .CONNECTED_OUT(con_out), .ACTIVITY_OUT(act_out),
    .PAGE_OUT(page_out), .PAGE_STROBE_OUT(strobe), .HOLD_OUT(hold)
  );

  spio_status_led_pager #(
    .NUM_DEVICES(6), .NUM_LEDS(4), .PAGE_REPEATS(2), .HOLD_REPEATS(8), .PAGE_BITS(2)
  ) dut6 (
    .CLK_IN(clk), .RESET_IN(rst_n),
    .ERROR_IN(err6), .CONNECTED_IN(con6), .ACTIVITY_IN(act6),
    .ANIMATION_REPEAT_IN(rep6),
    .OVERRIDE_VLD_IN(vld6), .OVERRIDE_PAGE_IN(pg6), .OVERRIDE_RDY_OUT(rdy6),
    .ERROR_OUT(err6_out), .CONNECTED_OUT(con6_out), .ACTIVITY_OUT(act6_out),
    .PAGE_OUT(page6_out), .PAGE_STROBE_OUT(strobe6), .HOLD_OUT(hold6)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model of the default instance
  int         m_page = 0, m_cnt = 0;
  bit         m_hold = 1'b0, m_rdy = 1'b0, m_strobe = 1'b0;
  logic [3:0] m_err = '0, m_con = '0, m_act = '0;
  bit [15:0]  m_pend = '0;

  always @(posedge clk or negedge rst_n) begin : model
    bit         xfer;
    int         d;
    logic [3:0] ne, nc, na;
    if (!rst_n) begin
      m_page = 0; m_cnt = 0; m_hold = 0; m_rdy = 0; m_strobe = 0;
      m_err = '0; m_con = '0; m_act = '0; m_pend = '0;
    end else begin
      xfer = vld && m_rdy;
      ne = '0; nc = '0; na = '0;
      for (int j = 0; j < NL; j++) begin
        d = m_page * NL + j;
        if (d < ND) begin
          if (((err_in >> d) & 16'd1) != 0) ne = ne | (4'd1 << j);
          if (((con_in >> d) & 16'd1) != 0) nc = nc | (4'd1 << j);
          if (((act_in >> d) & 16'd1) != 0 ||
              (STICKY && m_strobe && ((m_pend >> d) & 16'd1) != 0)) na = na | (4'd1 << j);
        end
      end
      if (STICKY) begin
        for (int k = 0; k < ND; k++) begin
          if (k / NL != m_page) begin
            if (((act_in >> k) & 16'd1) != 0) m_pend = m_pend | (16'd1 << k);
          end else if (m_strobe) begin
            m_pend = m_pend & ~(16'd1 << k);
          end
        end
      end
      m_strobe = 1'b0;
      if (xfer) begin
        if (int'(ovr_page) < NP) begin
          m_page = int'(ovr_page); m_cnt = 0; m_hold = 1'b1; m_strobe = 1'b1;
        end
      end else if (rep) begin
        m_cnt++;
        if (m_hold && m_cnt == HR) begin
          m_cnt = 0; m_hold = 1'b0;
        end else if (!m_hold && m_cnt == PR) begin
          m_cnt = 0; m_page = (m_page + 1) % NP; m_strobe = 1'b1;
        end
      end
      m_rdy = !m_hold;
      m_err = ne; m_con = nc; m_act = na;
    end
  end

  // Per-cycle comparison of the default instance against the model
  always @(negedge clk) begin
    check("mdl_rdy", rdy, m_rdy);
    check("mdl_page", page_out, m_page);
    check("mdl_strobe", strobe, m_strobe);
    check("mdl_hold", hold, m_hold);
    check("mdl_err", err_out, m_err);
    check("mdl_con", con_out, m_con);
    check("mdl_act", act_out, m_act);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    rep = 1'b1;
    @(negedge clk);
    rep = 1'b0;
  endtask

  task automatic pulse6();
    rep6 = 1'b1;
    @(negedge clk);
    rep6 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    cyc(3);
    check("rst_page", page_out, 0);
    check("rst_rdy", rdy, 0);
    check("rst_hold", hold, 0);
    check("rst_err", err_out, 0);
    rst_n = 1'b1;
    cyc(1);
    check("rdy_after_rst", rdy, 1);

    // Automatic scan through all pages
    err_in = 16'hA5C3;
    con_in = 16'h0F0F;
    for (int p = 1; p <= 4; p++) begin
      pulse();
      check("scan_hold_page", page_out, (p - 1) % 4);
      cyc(1);
      pulse();
      check("scan_page", page_out, p % 4);
      check("scan_strobe", strobe, 1);
      cyc(1);
      check("scan_strobe_clr", strobe, 0);
    end
    check("led_err_p0", err_out, 4'h3);
    check("led_con_p0", con_out, 4'hF);

    // Host holds page 2, then scanning resumes
    vld = 1'b1; ovr_page = 2'd2;
    @(negedge clk);
    vld = 1'b0;
    check("ovr_rdy", rdy, 0);
    check("ovr_page", page_out, 2);
    check("ovr_hold", hold, 1);
    check("ovr_strobe", strobe, 1);
    for (int i = 0; i < 7; i++) begin
      pulse();
      cyc(1);
    end
    check("hold_kept", hold, 1);
    pulse();
    check("hold_end", hold, 0);
    check("hold_end_rdy", rdy, 1);
    check("hold_end_page", page_out, 2);
    cyc(1);
    pulse();
    cyc(1);
    pulse();
    check("resume_page", page_out, 3);

    // Activity on device 5 while page 0 is shown
    cyc(1);
    pulse();
    cyc(1);
    pulse();
    check("sticky_p0", page_out, 0);
    cyc(1);
    act_in = 16'h0020;
    @(negedge clk);
    act_in = 16'h0000;
    pulse();
    cyc(1);
    pulse();
    check("sticky_p1", page_out, 1);
    check("sticky_first", act_out, 0);
    cyc(1);
    check("sticky_flash", act_out, STICKY ? 4'b0010 : 4'b0000);
    cyc(1);
    check("sticky_gone", act_out, 0);

    // Transfer coincident with a repeat pulse, then reset mid-hold
    rep = 1'b1; vld = 1'b1; ovr_page = 2'd3;
    @(negedge clk);
    rep = 1'b0; vld = 1'b0;
    check("prio_page", page_out, 3);
    check("prio_hold", hold, 1);
    for (int i = 0; i < 7; i++) begin
      pulse();
      cyc(1);
    end
    check("prio_uncounted", hold, 1);
    rst_n = 1'b0;
    #1;
    check("arst_page", page_out, 0);
    check("arst_hold", hold, 0);
    check("arst_rdy", rdy, 0);
    check("arst_err", err_out, 0);
    check("arst_con", con_out, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    check("post_rst_rdy", rdy, 1);
    check("post_rst_hold", hold, 0);

    // Small instance: 2 real pages, pages 2-3 invalid
    pulse6();
    cyc(1);
    vld6 = 1'b1; pg6 = 2'd3;
    @(negedge clk);
    pg6 = 2'd2;
    @(negedge clk);
    vld6 = 1'b0;
    check("inv_rdy", rdy6, 1);
    check("inv_page", page6_out, 0);
    check("inv_hold", hold6, 0);
    check("inv_strobe", strobe6, 0);
    pulse6();
    check("inv_cnt_kept", page6_out, 1);
    check("inv_strobe_adv", strobe6, 1);
    err6 = 6'b10_1010; con6 = 6'b01_0000; act6 = 6'b11_0000;
    cyc(1);
    check("p1_err", err6_out, 4'b0010);
    check("p1_con", con6_out, 4'b0001);
    check("p1_act", act6_out, 4'b0011);
    err6 = 6'b01_1111;
    cyc(1);
    check("p1_err2", err6_out, 4'b0001);
    vld6 = 1'b1; pg6 = 2'd1;
    @(negedge clk);
    vld6 = 1'b0;
    check("same_page_strobe", strobe6, 1);
    check("same_page_hold", hold6, 1);
    check("same_page_page", page6_out, 1);
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
